data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Memory-side responder for the CPU's load/store path. It accepts one RV32I data-memory request at a time over a valid/ready handshake and applies byte lanes by `funct3` (byte/half/word, signed/unsigned loads). It inserts a parameterised number of wait states and returns load data or an error flag over a valid/ready response channel. It replaces the zero-latency combinational data memory so the core and its bench can be exercised against a realistic, stalling memory.

## Interface
- `DEPTH_WORDS`, default 1024: number of 32-bit words stored.
- `LATENCY`, default 2: wait cycles between request accept and response, legal range 0..15.
- `ADDR_BASE`, default 32'h0000_0000: byte address of word 0.

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I load/store `funct3`.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  load result, extended to 32 bits; 0 for stores and errors.
- `rsp_err`  out  1  request was illegal, misaligned or out of range.

## Operation
- FSM states:
  - **IDLE**: `req_ready` is 1. A handshake (`req_valid && req_ready`) latches `we`, `funct3`, `addr` and `wdata`, then moves to WAIT, or directly to RESP when `LATENCY` = 0.
  - **WAIT**: a 4-bit counter counts `LATENCY` cycles. On the last wait cycle the access executes: a store commits to the RAM, or load data is captured into the `rsp_rdata` register. The FSM then moves to RESP.
  - **RESP**: `rsp_valid` is 1. On `rsp_valid && rsp_ready`, return to IDLE.
- Error checks, evaluated on the latched request. Any failing check sets `rsp_err` = 1, suppresses the RAM write and forces `rsp_rdata` to 0. Latency is unchanged.
  - funct3 legality: loads accept 000, 001, 010, 100, 101; stores accept 000, 001, 010. Everything else is illegal.
  - Alignment: a halfword with `addr[0]` = 1, or a word with `addr[1:0]` ≠ 0, is misaligned.
  - Range: the access is out of range if `addr < ADDR_BASE` or `(addr - ADDR_BASE) >> 2 >= DEPTH_WORDS`.
- Stores:
  - SB writes `wdata[7:0]` to lane `addr[1:0]`.
  - SH writes `wdata[15:0]` to lanes {`addr[1]`, 0..1}.
  - SW writes all 4 lanes.
  - Unselected lanes are unchanged.
- Loads: extract the selected lane(s). LB and LH sign-extend. LBU and LHU zero-extend. LW is a passthrough.
- Reset clears the FSM, counter, `rsp_rdata` and `rsp_err`. RAM contents are **not** cleared by reset.

## Timing
- A request accepted in cycle N raises `rsp_valid` in cycle N+`LATENCY`+1.
- `req_ready` = (state == IDLE) && !`reset`. It drops in the cycle after accept.
- The earliest next accept is the cycle after the response handshake. Throughput is one request per `LATENCY`+2 cycles when `rsp_ready` is held at 1.
- While `rsp_valid` = 1 and `rsp_ready` = 0, `rsp_rdata` and `rsp_err` stay stable and no request is accepted.
- A load issued after a store's response to the same address returns the stored data.
- Reset values: `req_ready` = 1 (in the cycle after reset deasserts; 0 while `reset` is high), `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
- Reset during WAIT before the commit cycle abandons the pending store; the RAM is unmodified.
- Reset in RESP drops `rsp_valid` in the next cycle; the response is lost.
- Simultaneous `reset` and `req_valid`: the request is not accepted.

## Structure
- Package `mem_pkg` holds:
  - `funct3` constants: `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - State enum `rsp_state_t` {IDLE, WAIT, RESP}.
  - Helper function `lane_mask(funct3, addr)` returning a 4-bit byte enable.
- Sub-module `byte_ram`:
  - `DEPTH_WORDS` x 32-bit storage.
  - 4-bit byte-enable synchronous write.
  - Combinational read.
  - No reset.
- The top module holds the FSM, counter, request latches, error checks, lane steering and extension.

## Test plan
All scenarios use `LATENCY` = 2 and `ADDR_BASE` = 0 unless stated.
- SW 0xDEADBEEF @0x10, then LW @0x10 -> `rdata` = 0xDEADBEEF, `err` = 0, `rsp_valid` rises 3 cycles after each accept.
- SB `wdata` = 0x80 @0x13, then:
  - LB @0x13 -> 0xFFFFFF80.
  - LBU @0x13 -> 0x00000080.
  - LW @0x10 -> 0x80ADBEEF.
  - LH @0x12 -> 0xFFFF80AD.
- Errors, each with `err` = 1 and `rdata` = 0:
  - LH @0x11.
  - SW @0x12, after which LW @0x10 still returns 0x80ADBEEF.
  - LW @0x1000 with `DEPTH_WORDS` = 1024.
  - Store with `funct3` = 100.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles with `req_valid` = 1 -> `rsp_valid`, `rdata` and `err` stay stable, `req_ready` = 0, and the second request is accepted only in the cycle after the response handshake.
- Reset mid-operation:
  - SW 0x12345678 @0x20 (prior content 0) with `reset` pulsed in the first WAIT cycle -> `rsp_valid` = 0, `req_ready` = 1 after reset, and LW @0x20 returns 0.
  - With `LATENCY` = 0, a load accepted in cycle N -> `rsp_valid` in cycle N+1.

Source files
------------

// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM states
// and the byte-enable helper used for store lane selection.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rsp_state_t;

  // Byte enables touched by an access; zero for encodings with no defined width.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3)
      F3_B, F3_BU: lane_mask = 4'b0001 << addr;
      F3_H, F3_HU: lane_mask = addr[1] ? 4'b1100 : 4'b0011;
      F3_W:        lane_mask = 4'b1111;
      default:     lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_responder_byte_ram.sv
// Word-organised storage with per-byte synchronous write and combinational read.
// Contents are deliberately left out of reset.
module byte_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Stalling RV32I data-memory responder: one request in flight, LATENCY wait
// states, byte-lane steering and load extension, error flag on bad requests.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output rsp_state_t  dbg_state
);

  localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(LATENCY - 1);

  rsp_state_t  state;
  logic [3:0]  cnt;
  logic        l_we;
  logic [2:0]  l_f3;
  logic [31:0] l_addr, l_wdata;

  logic        a_we;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wdata;
  logic        accept, exec;
  logic        f3_ok, misaligned, out_of_range, err;
  logic [29:0] widx;
  logic [3:0]  be;
  logic [31:0] wsteer, ram_rdata, shifted, load_val;

  // Valid/ready on both channels: a transfer happens on a rising edge where
  // valid and ready are both 1; the producer holds its payload stable until then.
  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign dbg_state = state;

  // With zero latency the access executes on the accept edge from the live request.
  always_comb begin
    a_we    = l_we;
    a_f3    = l_f3;
    a_addr  = l_addr;
    a_wdata = l_wdata;
    if (state == IDLE) begin
      a_we    = req_we;
      a_f3    = req_funct3;
      a_addr  = req_addr;
      a_wdata = req_wdata;
    end
  end

  assign exec = ((state == WAIT) && (cnt == 4'd0)) || ((LATENCY == 0) && accept);

  always_comb begin
    case (a_f3)
      F3_B, F3_H, F3_W: f3_ok = 1'b1;
      F3_BU, F3_HU:     f3_ok = !a_we;
      default:          f3_ok = 1'b0;
    endcase
    case (a_f3)
      F3_H, F3_HU: misaligned = a_addr[0];
      F3_W:        misaligned = |a_addr[1:0];
      default:     misaligned = 1'b0;
    endcase
  end

  assign widx         = 30'((a_addr - ADDR_BASE) >> 2);
  assign out_of_range = (a_addr < ADDR_BASE) || ({2'b00, widx} >= 32'(DEPTH_WORDS));
  assign err          = !f3_ok || misaligned || out_of_range;

  // Replicate narrow store data across the word so the byte enables pick the lane.
  always_comb begin
    case (a_f3)
      F3_B:    wsteer = {4{a_wdata[7:0]}};
      F3_H:    wsteer = {2{a_wdata[15:0]}};
      default: wsteer = a_wdata;
    endcase
  end

  assign be = (exec && a_we && !err && !reset) ? lane_mask(a_f3, a_addr[1:0]) : 4'b0000;

  byte_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .be   (be),
    .addr (widx[AW-1:0]),
    .wdata(wsteer),
    .rdata(ram_rdata)
  );

  assign shifted = ram_rdata >> {a_addr[1:0], 3'b000};

  always_comb begin
    case (a_f3)
      F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   load_val = {24'd0, shifted[7:0]};
      F3_HU:   load_val = {16'd0, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if (exec) begin
        rsp_err   <= err;
        rsp_rdata <= (err || a_we) ? 32'd0 : load_val;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            l_we    <= req_we;
            l_f3    <= req_funct3;
            l_addr  <= req_addr;
            l_wdata <= req_wdata;
            if (LATENCY == 0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Drives a LATENCY=2 and a LATENCY=0 responder with the same request stream and
// checks both against a byte-array memory model.
module tb_data_mem_responder;
  import mem_pkg::*;

  localparam int MEM_BYTES = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        req_ready0, rsp_valid0, rsp_err0;
  logic        req_ready1, rsp_valid1, rsp_err1;
  logic [31:0] rsp_rdata0, rsp_rdata1;
  rsp_state_t  dbg0, dbg1;

  int n_vec  = 0;
  int n_fail = 0;

  logic [7:0] mem_m [2][MEM_BYTES];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .ADDR_BASE(32'h0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready0),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0),
    .rsp_err(rsp_err0), .dbg_state(dbg0)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(0), .ADDR_BASE(32'h0)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready1),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1),
    .rsp_err(rsp_err1), .dbg_state(dbg1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: little-endian byte memory, access width from funct3.
  function automatic void model(input int d, input logic we, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic err, output logic [31:0] rd);
    int size;
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    err = we ? (f3 > 3'd2) : (size == 0);
    if (!err) err = ((addr % 32'(size)) != 0) || (addr >= 32'(MEM_BYTES));
    rd = 32'd0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < size; i++) mem_m[d][int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = 32'd0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = mem_m[d][int'(addr) + i];
        if (f3 == 3'd0) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'd1) v = {{16{v[15]}}, v[15:0]};
        rd = v;
      end
    end
  endfunction

  // Called at the negedge of the cycle after accept, with rsp_ready = 1.
  task automatic collect(input logic e0, input logic [31:0] r0, input logic e1, input logic [31:0] r1);
    int t0 = -1;
    int t1 = -1;
    for (int k = 1; k <= 12; k++) begin
      if (t0 < 0 && rsp_valid0) begin
        t0 = k;
        chk("rdata_l2", rsp_rdata0, r0);
        chk("err_l2", 32'(rsp_err0), 32'(e0));
      end
      if (t1 < 0 && rsp_valid1) begin
        t1 = k;
        chk("rdata_l0", rsp_rdata1, r1);
        chk("err_l0", 32'(rsp_err1), 32'(e1));
      end
      if (k == 1) chk("ready_drop_l2", 32'(req_ready0), 32'd0);
      if (t0 >= 0 && t1 >= 0) break;
      @(negedge clk);
    end
    chk("latency_l2", 32'(t0), 32'd3);
    chk("latency_l0", 32'(t1), 32'd1);
  endtask

  task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
    logic e0, e1;
    logic [31:0] r0, r1;
    model(0, we, f3, addr, wdata, e0, r0);
    model(1, we, f3, addr, wdata, e1, r1);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    chk("req_ready_idle", {30'd0, req_ready1, req_ready0}, 32'd3);
    @(negedge clk);
    req_valid = 1'b0;
    collect(e0, r0, e1, r1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ea0, ea1, eb0, eb1;
    logic [31:0] ra0, ra1, rb0, rb1;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("ready_in_reset", {30'd0, req_ready1, req_ready0}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_ready", {30'd0, req_ready1, req_ready0}, 32'd3);
    chk("rst_valid", {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
    chk("rst_rdata", rsp_rdata0 | rsp_rdata1, 32'd0);
    chk("rst_err", {30'd0, rsp_err1, rsp_err0}, 32'd0);
    chk("rst_state", 32'(dbg0), 32'(IDLE));

    // Known contents for the region the random phase touches.
    for (int a = 0; a < 256; a += 4) xfer(1'b1, F3_W, 32'(a), 32'd0);

    xfer(1'b1, F3_W, 32'h10, 32'hDEADBEEF);
    xfer(1'b0, F3_W, 32'h10, 32'd0);
    xfer(1'b1, F3_B, 32'h13, 32'h0000_0080);
    xfer(1'b0, F3_B, 32'h13, 32'd0);
    xfer(1'b0, F3_BU, 32'h13, 32'd0);
    xfer(1'b0, F3_W, 32'h10, 32'd0);
    xfer(1'b0, F3_H, 32'h12, 32'd0);
    xfer(1'b0, F3_HU, 32'h12, 32'd0);
    xfer(1'b0, F3_H, 32'h11, 32'd0);
    xfer(1'b1, F3_W, 32'h12, 32'hCAFEF00D);
    xfer(1'b0, F3_W, 32'h10, 32'd0);
    xfer(1'b0, F3_W, 32'h1000, 32'd0);
    xfer(1'b1, 3'b100, 32'h14, 32'h1111_1111);
    xfer(1'b0, F3_W, 32'h14, 32'd0);
    xfer(1'b1, F3_H, 32'h1A, 32'hAAAA_9876);
    xfer(1'b0, F3_W, 32'h18, 32'd0);
    xfer(1'b0, 3'b011, 32'h18, 32'd0);

    // Backpressure: response held while a second request waits on the bus.
    model(0, 1'b0, F3_W, 32'h10, 32'd0, ea0, ra0);
    model(1, 1'b0, F3_W, 32'h10, 32'd0, ea1, ra1);
    model(0, 1'b0, F3_BU, 32'h13, 32'd0, eb0, rb0);
    model(1, 1'b0, F3_BU, 32'h13, 32'd0, eb1, rb1);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h10;
    @(negedge clk);
    req_funct3 = F3_BU; req_addr = 32'h13;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", {30'd0, rsp_valid1, rsp_valid0}, 32'd3);
      chk("bp_rdata_l2", rsp_rdata0, ra0);
      chk("bp_rdata_l0", rsp_rdata1, ra1);
      chk("bp_err", {30'd0, rsp_err1, rsp_err0}, {30'd0, ea1, ea0});
      chk("bp_ready", {30'd0, req_ready1, req_ready0}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp_valid0), 32'd0);
    chk("bp_release_ready", 32'(req_ready0), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    collect(eb0, rb0, eb1, rb1);

    // Reset in the first wait cycle: the LATENCY=2 store is abandoned, while the
    // LATENCY=0 instance already committed on the accept edge.
    model(1, 1'b1, F3_W, 32'h20, 32'h12345678, ea1, ra1);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0; reset = 1'b1;
    #1;
    chk("mid_reset_ready", 32'(req_ready0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_reset_valid", {30'd0, rsp_valid1, rsp_valid0}, 32'd0);
    chk("post_reset_ready", {30'd0, req_ready1, req_ready0}, 32'd3);
    chk("post_reset_rdata", rsp_rdata0, 32'd0);
    xfer(1'b0, F3_W, 32'h20, 32'd0);

    for (int n = 0; n < 300; n++) begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      we = ($urandom_range(0, 2) == 0);
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       addr = 32'h1000 + 32'($urandom_range(0, 255));
        1:       addr = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        default: addr = 32'($urandom_range(0, 255));
      endcase
      xfer(we, f3, addr, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
